// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing controller: datapath sizes,
// opcode encodings, the controller FSM state and the latched command record.
package alu_pkg;

  localparam int DATA_W  = 17;
  // Arithmetic ops wrap to this many bits; anything above it raises overflow.
  localparam int ARITH_W = 16;
  localparam int NREGS   = 8;
  localparam int REG_AW  = $clog2(NREGS);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_MULT = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } alu_ctrl_state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;
  } alu_cmd_t;

endpackage

// File: rtl/alu.sv
// Combinational 17-bit ALU. ADD, SUB and MULT produce a result wrapped to
// ARITH_W bits and flag overflow when the exact result does not fit (for SUB,
// when the subtrahend is larger). AND/OR/XOR operate on the full width and
// never overflow. Opcodes outside the ALU set yield zero.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] src1_data,
  input  logic [DATA_W-1:0] src2_data,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] dest_data,
  output logic              overflow
);

  localparam int WIDE_W = 2 * DATA_W;

  logic [WIDE_W-1:0]  src1_wide;
  logic [WIDE_W-1:0]  src2_wide;
  logic [WIDE_W-1:0]  sum_wide;
  logic [WIDE_W-1:0]  prod_wide;
  logic [ARITH_W-1:0] diff;

  assign src1_wide = WIDE_W'(src1_data);
  assign src2_wide = WIDE_W'(src2_data);
  assign sum_wide  = src1_wide + src2_wide;
  assign prod_wide = src1_wide * src2_wide;
  assign diff      = src1_data[ARITH_W-1:0] - src2_data[ARITH_W-1:0];

  // Select the result and overflow flag for the requested operation.
  always_comb begin
    dest_data = '0;
    overflow  = 1'b0;
    case (opcode)
      OP_ADD: begin
        dest_data = DATA_W'(sum_wide[ARITH_W-1:0]);
        overflow  = |sum_wide[WIDE_W-1:ARITH_W];
      end
      OP_SUB: begin
        dest_data = DATA_W'(diff);
        overflow  = (src1_data < src2_data);
      end
      OP_AND:  dest_data = src1_data & src2_data;
      OP_OR:   dest_data = src1_data | src2_data;
      OP_XOR:  dest_data = src1_data ^ src2_data;
      OP_MULT: begin
        dest_data = DATA_W'(prod_wide[ARITH_W-1:0]);
        overflow  = |prod_wide[WIDE_W-1:ARITH_W];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_regfile.sv
// 8 x 17 register file: two asynchronous read ports, one synchronous write
// port, and a synchronous clear of every entry while rst is high.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [NREGS];

  // Clear all entries on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk) begin
    // NOTE: clearing a whole array on reset rules out a RAM macro; it is
    // intended here because the file must read as zero after every reset.
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing controller around the combinational alu. Accepts one command at
// a time, executes it against the register file in a single EXEC cycle,
// registers the response and holds it until the consumer takes it.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_overflow,
  output logic              rsp_err,
  output logic              ovf_sticky,
  input  logic              clr_ovf
);

  alu_ctrl_state_t   state;
  alu_ctrl_state_t   state_nxt;
  alu_cmd_t          cmd_q;
  logic              rf_we;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ovf;
  logic [DATA_W-1:0] res_data;
  logic              res_ovf;
  logic              res_err;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so register order inside and across blocks does not matter.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept, execute for one cycle, wait for the consumer.
  always_comb begin
    // NOTE: defaulting first means every path assigns state_nxt, so no latch.
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake flags and the register-file write strobe.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rf_we     = 1'b0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_EXEC: rf_we     = (cmd_q.op != OP_RSVD);
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the command on acceptance so the alu sees stable inputs in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q <= '0;
    end else if (state == ST_IDLE && cmd_valid) begin
      cmd_q <= '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2, imm: cmd_imm};
    end
  end

  alu_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (rf_we),
    .waddr  (cmd_q.rd),
    .wdata  (res_data),
    .raddr1 (cmd_q.rs1),
    .raddr2 (cmd_q.rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  alu u_alu (
    .src1_data (rs1_data),
    .src2_data (rs2_data),
    .opcode    (cmd_q.op),
    .dest_data (alu_data),
    .overflow  (alu_ovf)
  );

  // Result select: alu output passes through untouched; LOAD and reserved
  // opcodes substitute their own values.
  always_comb begin
    res_data = alu_data;
    res_ovf  = alu_ovf;
    res_err  = 1'b0;
    case (cmd_q.op)
      OP_LOAD: begin
        res_data = cmd_q.imm;
        res_ovf  = 1'b0;
      end
      OP_RSVD: begin
        res_data = '0;
        res_ovf  = 1'b0;
        res_err  = 1'b1;
      end
      default: ;
    endcase
  end

  // Response register: loaded at the end of EXEC, held through RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data     <= '0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_data     <= res_data;
      rsp_overflow <= res_ovf;
      rsp_err      <= res_err;
    end
  end

  // Sticky overflow: a new overflow wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (state == ST_EXEC && res_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Sequencing controller for the 17-bit combinational `alu` (ADD/SUB/AND/OR/XOR/MULT). It accepts register-level commands over a valid/ready handshake and owns an 8-entry × 17-bit register file. For each command it reads the operands, drives the `alu`, writes the result back and returns a response. It also keeps a sticky overflow status, so software-style command streams can run the ALU without a testbench driving its pins.

## Interface
- `DATA_W`, 17: datapath width; must match `alu`.
- `NREGS`, 8: register-file depth; index width is `clog2(NREGS)` = 3.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  opcode:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MULT;
  - 110 LOAD;
  - 111 reserved.
- `cmd_rd`, `cmd_rs1`, `cmd_rs2`  in  3 each  destination and source register indices.
- `cmd_imm`  in  17  immediate, used only by LOAD.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  17  value written to `rd`.
- `rsp_overflow`  out  1  `alu` overflow for this command.
- `rsp_err`  out  1  reserved opcode was issued.
- `ovf_sticky`  out  1  OR of every `rsp_overflow` since the last clear.
- `clr_ovf`  in  1  clears `ovf_sticky`.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid`: latch op, rd, rs1, rs2 and imm, then go to EXEC.
- **EXEC**
  - `alu.src1_data` = rf[rs1], `alu.src2_data` = rf[rs2], `alu.opcode` = latched op.
  - The `alu` is driven only from latched fields, so it is stable for the whole cycle.
  - Register the response and write rf[rd], then go to RESP:
    - Ops 000–101: rsp_data = `dest_data`, rsp_overflow = `overflow`.
    - LOAD: rsp_data = imm, rsp_overflow = 0.
    - 111: no register write; rsp_data = 0, rsp_overflow = 0, rsp_err = 1.
- **RESP**
  - `rsp_valid` = 1; response fields are held constant until accepted.
  - On `rsp_ready`: go to IDLE.
- The controller treats `alu` results as opaque: it never modifies `dest_data` or `overflow`, including MULT.
- rd may equal rs1 or rs2. Operands are read in EXEC before the write edge, so the old value is used.
- Commands execute strictly in order, one in flight; there are no hazards.
- `ovf_sticky`:
  - Set on the EXEC→RESP edge when the registered overflow is 1.
  - Cleared by `clr_ovf`.
  - If set and clear happen in the same cycle, set wins.
- Register file is not externally readable. Contents are observed only through responses.

## Timing
- Reset values:
  - FSM = IDLE.
  - All rf entries = 0.
  - `cmd_ready` = 1 (IDLE combinational).
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_overflow` = 0, `rsp_err` = 0, `ovf_sticky` = 0.
- Latency, for a command accepted at edge N:
  - EXEC runs during cycle N..N+1.
  - rf write and response register happen at edge N+1.
  - `rsp_valid` is high after edge N+1.
  - With `rsp_ready` tied high, the next command is accepted at edge N+3. Peak throughput is one command per 3 cycles.
- Backpressure: while `rsp_valid`=1 and `rsp_ready`=0, the state stays in RESP, outputs are held and `cmd_ready`=0.
- `cmd_ready` is 0 in EXEC and RESP. A `cmd_valid` in those states is ignored, not dropped; the source must hold it.
- Reset mid-operation (EXEC or RESP): the command is abandoned, no response is issued, and rf is cleared.
- Reset has priority over every other event, including `clr_ovf`.

## Structure
- Package `alu_pkg` holds:
  - opcode localparams `OP_ADD`..`OP_MULT`, `OP_LOAD`, `OP_RSVD`;
  - `DATA_W`;
  - the FSM state enum `alu_ctrl_state_t`.
- The existing `alu` is instantiated unchanged.
- One natural sub-module: `alu_regfile`, with 2 async read ports, 1 sync write port and synchronous clear on `rst`.
- Expected size: about 200 RTL lines total.

## Test plan
- **Reset and LOAD.** Reset; LOAD r1=50, LOAD r2=25.
  - `rsp_data` = 50, then 25; `rsp_overflow` = 0.
  - Each `rsp_valid` appears 2 cycles after accept.
- **ADD and SUB.** After r1=50, r2=25:
  - ADD r3=r1+r2 → `rsp_data` = 75, `rsp_overflow` = 0.
  - SUB r4=r3−r1 → 25.
- **Overflow and sticky.**
  - LOAD r5=65536, LOAD r6=1, ADD r7=r5+r6 → `rsp_data` and `rsp_overflow` equal the `alu` outputs for (65536, 1) (1 and 1); `ovf_sticky` = 1.
  - Pulse `clr_ovf` in the same cycle as a new overflowing result → sticky stays 1.
  - Pulse `clr_ovf` alone → sticky = 0.
- **Logic ops and backpressure.**
  - Load 17'b10101010101010101 and 17'b11110000111100001.
  - AND, OR, XOR → 17'b10100000101000001, 17'b11111010111110101, 17'b01011010010110100.
  - Hold `rsp_ready`=0 for 5 cycles on the OR response → data held stable, `cmd_ready`=0 throughout.
- **Reserved opcode and aliasing.**
  - Op 111 → `rsp_err` = 1, `rsp_data` = 0, and no register changes (confirm by re-reading through ADD with a zero register).
  - ADD r1=r1+r1 with r1=50 → 100.
- **Reset mid-command.** Assert `rst` in EXEC → no `rsp_valid`; a following ADD r3=r1+r2 returns 0.
